// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// opcode encodings, control states and the default operand width.
package mdu_pkg;

    localparam int MDU_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        SIGN,
        DONE
    } mdu_state_e;

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the datapath control (master) and the
// multiply/divide unit (slave).
interface mult_div_unit_if
    import mdu_pkg::*;
#(
    parameter int DATA_WIDTH = MDU_DATA_WIDTH
);

    logic                  start;
    logic [1:0]            op;
    logic [DATA_WIDTH-1:0] src_a;
    logic [DATA_WIDTH-1:0] src_b;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] lo;
    logic                  div_by_zero;

    modport master (
        output start, op, src_a, src_b,
        input  busy, done, hi, lo, div_by_zero
    );

    modport slave (
        input  start, op, src_a, src_b,
        output busy, done, hi, lo, div_by_zero
    );

endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one operand bit per cycle on unsigned
// magnitudes, sign fix-up in a separate cycle, HI/LO held until the next result.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int DATA_WIDTH = MDU_DATA_WIDTH
) (
    input  logic           clk,
    input  logic           rst_n,
    mult_div_unit_if.slave bus
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    function automatic logic [W-1:0] neg_w(input logic [W-1:0] x);
        return -x;
    endfunction

    // Shift-add: multiplier sits in acc[W-1:0] and is consumed LSB first.
    function automatic logic [2*W-1:0] mul_step(input logic [2*W-1:0] acc,
                                                input logic [W-1:0]   mcand);
        logic [W:0] sum;
        sum = {1'b0, acc[2*W-1:W]} + {1'b0, mcand};
        if (acc[0]) return {sum, acc[W-1:1]};
        return {1'b0, acc[2*W-1:1]};
    endfunction

    // Restoring division step; returns {remainder, quotient/dividend shift}.
    function automatic logic [2*W:0] div_step(input logic [W:0]   rem,
                                              input logic [W-1:0] quo,
                                              input logic [W-1:0] dvsr);
        logic [W+1:0] shifted;
        logic [W+1:0] diff;
        shifted = {rem, quo[W-1]};
        diff    = shifted - {2'b00, dvsr};
        if (!diff[W+1]) return {diff[W:0], quo[W-2:0], 1'b1};
        return {shifted[W:0], quo[W-2:0], 1'b0};
    endfunction

    mdu_state_e     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    mdu_op_e        op_q, op_d;
    logic           sign_a_q, sign_a_d;
    logic           sign_x_q, sign_x_d;
    logic           bzero_q, bzero_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   lo_q, lo_d;
    logic           dbz_q, dbz_d;

    logic [2*W-1:0] acc_q, acc_d;
    logic [W:0]     rem_q, rem_d;
    logic [W-1:0]   opnd_q, opnd_d;
    logic [W-1:0]   orig_a_q, orig_a_d;

    logic           accept;
    logic           a_neg, b_neg;
    logic [W-1:0]   a_mag, b_mag;
    logic [2*W:0]   div_next;
    logic [2*W-1:0] prod;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_x_d = sign_x_q;
        bzero_d  = bzero_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dbz_d    = dbz_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        opnd_d   = opnd_q;
        orig_a_d = orig_a_q;

        a_neg    = bus.op[0] & bus.src_a[W-1];
        b_neg    = bus.op[0] & bus.src_b[W-1];
        a_mag    = a_neg ? neg_w(bus.src_a) : bus.src_a;
        b_mag    = b_neg ? neg_w(bus.src_b) : bus.src_b;
        accept   = bus.start && (state_q == IDLE || state_q == DONE);
        div_next = div_step(rem_q, acc_q[W-1:0], opnd_q);
        prod     = sign_x_q ? -acc_q : acc_q;

        case (state_q)
            IDLE: state_d = IDLE;
            CALC: begin
                if (op_q == OP_DIVU || op_q == OP_DIV) begin
                    {rem_d, acc_d[W-1:0]} = div_next;
                end else begin
                    acc_d = mul_step(acc_q, opnd_q);
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) state_d = SIGN;
            end
            SIGN: begin
                state_d = DONE;
                if (op_q == OP_DIVU || op_q == OP_DIV) begin
                    if (bzero_q) begin
                        hi_d  = orig_a_q;
                        lo_d  = '1;
                        dbz_d = 1'b1;
                    end else begin
                        lo_d  = sign_x_q ? neg_w(acc_q[W-1:0]) : acc_q[W-1:0];
                        hi_d  = sign_a_q ? neg_w(rem_q[W-1:0]) : rem_q[W-1:0];
                        dbz_d = 1'b0;
                    end
                end else begin
                    hi_d  = prod[2*W-1:W];
                    lo_d  = prod[W-1:0];
                    dbz_d = 1'b0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Acceptance overrides the IDLE/DONE defaults and loads the magnitudes.
        if (accept) begin
            state_d  = CALC;
            cnt_d    = CW'(W-1);
            op_d     = mdu_op_e'(bus.op);
            sign_a_d = a_neg;
            sign_x_d = a_neg ^ b_neg;
            bzero_d  = (bus.src_b == '0);
            orig_a_d = bus.src_a;
            rem_d    = '0;
            if (bus.op[1]) begin
                acc_d  = {{W{1'b0}}, a_mag};
                opnd_d = b_mag;
            end else begin
                acc_d  = {{W{1'b0}}, b_mag};
                opnd_d = a_mag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= OP_MULTU;
            sign_a_q <= 1'b0;
            sign_x_q <= 1'b0;
            bzero_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_x_q <= sign_x_d;
            bzero_q  <= bzero_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dbz_q    <= dbz_d;
        end
    end

    // Working registers are always reloaded on acceptance, so they need no reset.
    always_ff @(posedge clk) begin
        acc_q    <= acc_d;
        rem_q    <= rem_d;
        opnd_q   <= opnd_d;
        orig_a_q <= orig_a_d;
    end

    assign bus.busy        = (state_q == CALC) || (state_q == SIGN);
    assign bus.done        = (state_q == DONE);
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and randomized checks of mult_div_unit against a plain-arithmetic
// reference model of MULT/MULTU/DIV/DIVU.
module tb_mult_div_unit;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    mult_div_unit_if #(.DATA_WIDTH(32)) bus ();

    mult_div_unit #(.DATA_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {div_by_zero, hi, lo} computed with 64-bit integer arithmetic.
    function automatic logic [64:0] model(input logic [1:0] o,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint    sa;
        longint    sb;
        longint    q;
        longint    r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: begin
                p = {32'd0, a} * {32'd0, b};
                return {1'b0, p};
            end
            2'b01: begin
                p = sa * sb;
                return {1'b0, p};
            end
            default: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                if (o == 2'b10) return {1'b0, a % b, a / b};
                q = sa / sb;
                r = sa % sb;
                return {1'b0, r[31:0], q[31:0]};
            end
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of cycle 1.
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = o;
        bus.src_a = a;
        bus.src_b = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Returns at the negedge of the done cycle; optionally pulses start mid-operation.
    task automatic wait_done(input string tag, input logic [1:0] o,
                             input logic [31:0] a, input logic [31:0] b, input bit glitch);
        int          n;
        bit          busy_ok;
        logic [64:0] exp;
        n       = 1;
        busy_ok = 1'b1;
        while (bus.done !== 1'b1 && n < 40) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (glitch && (n == 5 || n == 33)) begin
                bus.start = 1'b1;
                bus.op    = 2'($urandom_range(0, 3));
                bus.src_a = $urandom;
                bus.src_b = $urandom;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        exp = model(o, a, b);
        chk({tag, " latency"}, 64'(n), 64'd34);
        chk({tag, " busy"}, 64'(busy_ok), 64'd1);
        chk({tag, " busy_at_done"}, 64'(bus.busy), 64'd0);
        chk({tag, " hi"}, 64'(bus.hi), 64'(exp[63:32]));
        chk({tag, " lo"}, 64'(bus.lo), 64'(exp[31:0]));
        chk({tag, " dbz"}, 64'(bus.div_by_zero), 64'(exp[64]));
    endtask

    task automatic run_single(input string tag, input logic [1:0] o,
                              input logic [31:0] a, input logic [31:0] b, input bit glitch);
        launch(o, a, b);
        wait_done(tag, o, a, b, glitch);
        @(negedge clk);
        chk({tag, " done_pulse"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        int          dcount;
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.src_a = '0;
        bus.src_b = '0;
        repeat (2) @(negedge clk);
        chk("rst busy", 64'(bus.busy), 64'd0);
        chk("rst done", 64'(bus.done), 64'd0);
        chk("rst hi", 64'(bus.hi), 64'd0);
        chk("rst lo", 64'(bus.lo), 64'd0);
        chk("rst dbz", 64'(bus.div_by_zero), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_single("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("multu_max hi_const", 64'(bus.hi), 64'hFFFF_FFFE);
        chk("multu_max lo_const", 64'(bus.lo), 64'h0000_0001);
        run_single("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'd5, 1'b0);
        chk("mult_neg lo_const", 64'(bus.lo), 64'hFFFF_FFF1);
        run_single("div_neg", 2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("div_neg lo_const", 64'(bus.lo), 64'hFFFF_FFFD);
        chk("div_neg hi_const", 64'(bus.hi), 64'hFFFF_FFFF);
        run_single("divu_zero", 2'b10, 32'd100, 32'd0, 1'b0);
        chk("divu_zero dbz_const", 64'(bus.div_by_zero), 64'd1);
        run_single("multu_small", 2'b00, 32'd2, 32'd3, 1'b0);
        chk("multu_small dbz_clear", 64'(bus.div_by_zero), 64'd0);
        repeat (5) @(negedge clk);
        chk("hold hi", 64'(bus.hi), 64'd0);
        chk("hold lo", 64'(bus.lo), 64'd6);
        run_single("div_wrap", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("div_wrap lo_const", 64'(bus.lo), 64'h8000_0000);
        run_single("divu_big", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("divu_big hi_const", 64'(bus.hi), 64'h8000_0000);
        run_single("div_zero_neg", 2'b11, 32'hFFFF_FF00, 32'd0, 1'b0);

        run_single("multu_glitch", 2'b00, 32'd7, 32'd9, 1'b1);
        chk("multu_glitch lo_const", 64'(bus.lo), 64'd63);

        // Back-to-back: start held during the done cycle.
        launch(2'b00, 32'd12, 32'd13);
        wait_done("b2b_first", 2'b00, 32'd12, 32'd13, 1'b0);
        launch(2'b10, 32'd1000, 32'd7);
        wait_done("b2b_second", 2'b10, 32'd1000, 32'd7, 1'b0);
        @(negedge clk);
        chk("b2b done_pulse", 64'(bus.done), 64'd0);

        for (int i = 0; i < 10; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 15));
            if ($urandom_range(0, 7) == 0) rb = '0;
            run_single($sformatf("rand%0d", i), ro, ra, rb, 1'b0);
        end

        // Asynchronous reset in cycle 10 of an operation.
        launch(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst busy", 64'(bus.busy), 64'd0);
        chk("midrst done", 64'(bus.done), 64'd0);
        chk("midrst hi", 64'(bus.hi), 64'd0);
        chk("midrst lo", 64'(bus.lo), 64'd0);
        chk("midrst dbz", 64'(bus.div_by_zero), 64'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        dcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) dcount++;
        end
        chk("midrst no_done", 64'(dcount), 64'd0);
        chk("midrst idle", 64'(bus.busy), 64'd0);
        run_single("after_rst", 2'b11, 32'hFFFF_FF9C, 32'd7, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
